// File: rtl/dac_mem_scheduler_pkg.sv
// dac_mem_scheduler_pkg: sizes, FSM states and checkerboard bank mapping for the output-memory scheduler
package dac_mem_scheduler_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int NUM_BYTES = 8 * (2 ** ADDR_W);
  localparam int CNT_W = $clog2(DATA_W);
  localparam int IDX_W = $clog2(NUM_BYTES);
  typedef enum logic [1:0] {COLLECT, FILL, DONE} state_t;
  // strobe order {even4..even1, odd4..odd1}; even bank when row and column parities differ
  function automatic logic [7:0] bank_sel(input logic [IDX_W-1:0] n);
    return 8'(1) << {n[3] ^ n[0], n[IDX_W-1 -: 2]};
  endfunction
endpackage

// File: rtl/dac_mem_scheduler_if.sv
// dac_mem_scheduler_if: serial input stream and the eight-bank output-memory write port
interface dac_mem_scheduler_if;
  import dac_mem_scheduler_pkg::*;
  logic so_data, so_valid, pi_end;
  logic [DATA_W-1:0] oem_dataout;
  logic [ADDR_W-1:0] oem_addr;
  logic odd1_wr, odd2_wr, odd3_wr, odd4_wr;
  logic even1_wr, even2_wr, even3_wr, even4_wr;
  logic oem_finish;
  modport master (
    input so_data, so_valid, pi_end,
    output oem_dataout, oem_addr, odd1_wr, odd2_wr, odd3_wr, odd4_wr,
    output even1_wr, even2_wr, even3_wr, even4_wr, oem_finish
  );
  modport slave (
    output so_data, so_valid, pi_end,
    input oem_dataout, oem_addr, odd1_wr, odd2_wr, odd3_wr, odd4_wr,
    input even1_wr, even2_wr, even3_wr, even4_wr, oem_finish
  );
endinterface

// File: rtl/dac_mem_scheduler_addr_map.sv
// dac_mem_scheduler_addr_map: byte index to bank address and one-hot write strobe
module dac_mem_scheduler_addr_map
  import dac_mem_scheduler_pkg::*;
(
  input  logic [IDX_W-1:0]  n,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        strb
);
  assign addr = n[ADDR_W:1];
  assign strb = bank_sel(n);
endmodule

// File: rtl/dac_mem_scheduler.sv
// dac_mem_scheduler: packs the serial stream into bytes, writes them across the eight banks,
// then zero-fills the remainder after pi_end and signals completion
module dac_mem_scheduler
  import dac_mem_scheduler_pkg::*;
(
  input logic clk,
  input logic reset,
  dac_mem_scheduler_if.master bus
);
  state_t state, state_nx;
  logic [DATA_W-1:0] shreg, shreg_nx, data_nx, data_q;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nx;
  logic [IDX_W-1:0] byte_idx;
  logic [ADDR_W-1:0] map_addr, addr_q;
  logic [7:0] map_strb, strb_q;
  logic end_seen, ended, last, wr, finish_q;
  dac_mem_scheduler_addr_map u_map (.n(byte_idx), .addr(map_addr), .strb(map_strb));
  assign ended = end_seen | bus.pi_end;
  assign last = byte_idx == IDX_W'(NUM_BYTES - 1);
  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    bit_cnt_nx = bit_cnt;
    data_nx = '0;
    wr = 1'b0;
    if (state == COLLECT) begin
      if (bus.so_valid) begin
        shreg_nx = {shreg[DATA_W-2:0], bus.so_data};
        bit_cnt_nx = bit_cnt + 1'b1;
        wr = bit_cnt == CNT_W'(DATA_W - 1);
        data_nx = shreg_nx;
      end else if (ended && bit_cnt != '0) begin
        wr = 1'b1;
        data_nx = shreg << (DATA_W - int'(bit_cnt));
        bit_cnt_nx = '0;
      end else if (ended) state_nx = FILL;
    end else if (state == FILL) wr = 1'b1;
    if (wr && last) state_nx = DONE;
  end
  // write outputs load on the same edge that completes a byte, giving one cycle of latency
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= COLLECT;
      shreg <= '0;
      bit_cnt <= '0;
      byte_idx <= '0;
      end_seen <= 1'b0;
      data_q <= '0;
      addr_q <= '0;
      strb_q <= '0;
      finish_q <= 1'b0;
    end else begin
      state <= state_nx;
      shreg <= shreg_nx;
      bit_cnt <= bit_cnt_nx;
      byte_idx <= byte_idx + IDX_W'(wr && !last);
      end_seen <= ended;
      data_q <= wr ? data_nx : '0;
      addr_q <= wr ? map_addr : '0;
      strb_q <= wr ? map_strb : '0;
      finish_q <= state == DONE;
    end
  end
  assign bus.oem_dataout = data_q;
  assign bus.oem_addr = addr_q;
  assign bus.oem_finish = finish_q;
  assign {bus.even4_wr, bus.even3_wr, bus.even2_wr, bus.even1_wr,
          bus.odd4_wr, bus.odd3_wr, bus.odd2_wr, bus.odd1_wr} = strb_q;
endmodule
